pc_seq_ctrl: RTL and testbench

Fetch sequencer and return-address-stack controller for the program counter block. Each cycle it drives the PC select code, the jump target and the return address, gated by an instruction-memory ready handshake. Calls push a return address onto an internal LIFO and returns pop it. The block sits between decode/branch resolution and the PC, and is the only driver of the PC's ps_in, ia_in and ra_in.

---
 rtl/pc_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl
// Fetch sequencer and return-address-stack controller for the program counter.
// Each cycle it picks the PC select code, the jump target and the return
// address. Calls push pc_in+1 onto an internal LIFO and returns pop it.
// Requests are only honoured while fetching and when imem_ready_in is high.
//
// Ports:
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   imem_ready_in : instruction memory accepted the fetch this cycle
//   jump_in       : unconditional / taken-branch request
//   call_in       : call request (push pc_in+1, jump to target_in)
//   ret_in        : return request (pop, load top of stack)
//   target_in     : jump/call target address
//   pc_in         : current PC value
//   halt_in       : halt request
//   resume_in     : leave HALT
//   ps_out        : PC select (00 hold, 01 increment, 10 load ia, 11 load ra)
//   ia_out        : jump target to the PC (zero unless ps_out is 10)
//   ra_out        : top of the return-address stack (zero when empty)
//   imem_req_out  : fetch request to instruction memory
//   depth_out     : current stack occupancy
//   err_out       : sticky stack overflow/underflow flag
module pc_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       imem_ready_in,
  input  logic                       jump_in,
  input  logic                       call_in,
  input  logic                       ret_in,
  input  logic [AW-1:0]              target_in,
  input  logic [AW-1:0]              pc_in,
  input  logic                       halt_in,
  input  logic                       resume_in,
  output logic [1:0]                 ps_out,
  output logic [AW-1:0]              ia_out,
  output logic [AW-1:0]              ra_out,
  output logic                       imem_req_out,
  output logic [$clog2(DEPTH+1)-1:0] depth_out,
  output logic                       err_out
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_IA   = 2'b10;
  localparam logic [1:0] PS_RA   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HALT  = 2'b10,
    ST_ERROR = 2'b11
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  sp_q, sp_d;
  logic           err_q, err_d;
  logic [AW-1:0]  stack_q [DEPTH];
  logic [AW-1:0]  stack_d [DEPTH];

  logic [1:0]     ps_s;
  logic           req_s;
  logic [PW-1:0]  top_idx_s;
  logic [AW-1:0]  top_s;

  // The low PW bits of sp_q minus one address the top entry; when the stack
  // is full those bits are zero and the subtraction wraps to DEPTH-1.
  assign top_idx_s = sp_q[PW-1:0] - PW'(1);

  // Top-of-stack view, forced to zero when the stack is empty.
  always_comb begin
    top_s = {AW{1'b0}};
    if (sp_q != {DW{1'b0}}) begin
      top_s = stack_q[top_idx_s];
    end else begin
      top_s = {AW{1'b0}};
    end
  end

  // Next-state, stack update and PC-select decode.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    err_d   = err_q;
    stack_d = stack_q;
    ps_s    = PS_HOLD;
    req_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        req_s = 1'b1;
        if (halt_in) begin
          state_d = ST_HALT;
        end else if (!imem_ready_in) begin
          ps_s = PS_HOLD;
        end else if (ret_in) begin
          // ret outranks call, so one acceptance never pushes and pops.
          if (sp_q != {DW{1'b0}}) begin
            ps_s = PS_RA;
            sp_d = sp_q - DW'(1);
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end else if (call_in) begin
          if (sp_q != DW'(DEPTH)) begin
            ps_s                   = PS_IA;
            stack_d[sp_q[PW-1:0]]  = pc_in + AW'(1);
            sp_d                   = sp_q + DW'(1);
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end else if (jump_in) begin
          ps_s = PS_IA;
        end else begin
          ps_s = PS_INC;
        end
      end
      ST_HALT: begin
        if (resume_in) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_ERROR: begin
        err_d   = 1'b1;
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, stack pointer, error flag and stack storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sp_q    <= {DW{1'b0}};
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= {AW{1'b0}};
      end
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign ps_out       = ps_s;
  assign ia_out       = (ps_s == PS_IA) ? target_in : {AW{1'b0}};
  assign ra_out       = top_s;
  assign imem_req_out = req_s;
  assign depth_out    = sp_q;
  assign err_out      = err_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Testbench for pc_seq_ctrl. Inputs change on the falling edge and outputs are
// sampled 1ns later. A LIFO model queue receives pc_in+1 when a call is driven
// and is popped to produce the expected ra_out when a return is driven.
module tb_pc_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_ready_in, jump_in, call_in, ret_in, halt_in, resume_in;
  logic [15:0] target_in, pc_in;
  logic [1:0]  ps_out;
  logic [15:0] ia_out, ra_out;
  logic        imem_req_out;
  logic [3:0]  depth_out;
  logic        err_out;

  int checks   = 0;
  int failures = 0;
  logic [15:0] model_q[$];
  logic [15:0] exp_ra;

  pc_seq_ctrl #(.DEPTH(8), .AW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_ready_in(imem_ready_in), .jump_in(jump_in), .call_in(call_in),
    .ret_in(ret_in), .target_in(target_in), .pc_in(pc_in),
    .halt_in(halt_in), .resume_in(resume_in),
    .ps_out(ps_out), .ia_out(ia_out), .ra_out(ra_out),
    .imem_req_out(imem_req_out), .depth_out(depth_out), .err_out(err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic rdy, input logic j, input logic c, input logic r,
                      input logic h, input logic rs, input logic [15:0] tgt,
                      input logic [15:0] pc);
    @(negedge clk);
    imem_ready_in = rdy; jump_in = j; call_in = c; ret_in = r;
    halt_in = h; resume_in = rs; target_in = tgt; pc_in = pc;
    #1;
  endtask

  // Assert reset for two edges, release on a falling edge; state is IDLE after return.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready_in = 1'b1; jump_in = 1'b0; call_in = 1'b0; ret_in = 1'b0;
    halt_in = 1'b0; resume_in = 1'b0; target_in = 16'h0000; pc_in = 16'h0000;
    model_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ready_in = 1'b1; jump_in = 1'b1; call_in = 1'b0; ret_in = 1'b0;
    halt_in = 1'b0; resume_in = 1'b0; target_in = 16'h1234; pc_in = 16'h0000;
    #3;
    checks++; if (ps_out !== 2'b00) begin failures++; $display("FAIL reset_ps got=%b exp=00", ps_out); end
    checks++; if (imem_req_out !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req_out); end
    checks++; if (ia_out !== 16'h0000 || ra_out !== 16'h0000) begin failures++; $display("FAIL reset_ia_ra got=%h/%h exp=0000/0000", ia_out, ra_out); end
    checks++; if (depth_out !== 4'd0 || err_out !== 1'b0) begin failures++; $display("FAIL reset_depth_err got=%0d/%b exp=0/0", depth_out, err_out); end
  endtask

  task automatic test_fetch();
    do_reset();
    checks++; if (ps_out !== 2'b00 || imem_req_out !== 1'b0) begin failures++; $display("FAIL idle_cycle got ps=%b req=%b exp ps=00 req=0", ps_out, imem_req_out); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'(i));
      checks++; if (ps_out !== 2'b01 || imem_req_out !== 1'b1 || depth_out !== 4'd0) begin failures++; $display("FAIL fetch_inc[%0d] got ps=%b req=%b depth=%0d exp ps=01 req=1 depth=0", i, ps_out, imem_req_out, depth_out); end
    end
  endtask

  task automatic test_ready_stall();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0003);
      checks++; if (ps_out !== 2'b00 || ia_out !== 16'h0000) begin failures++; $display("FAIL stall[%0d] got ps=%b ia=%h exp ps=00 ia=0000", i, ps_out, ia_out); end
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0003);
    checks++; if (ps_out !== 2'b10 || ia_out !== 16'h0040) begin failures++; $display("FAIL stall_release got ps=%b ia=%h exp ps=10 ia=0040", ps_out, ia_out); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0040);
    checks++; if (ps_out !== 2'b01 || ia_out !== 16'h0000) begin failures++; $display("FAIL after_jump got ps=%b ia=%h exp ps=01 ia=0000", ps_out, ia_out); end
  endtask

  task automatic test_call_ret();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0010);
    model_q.push_back(16'h0010 + 16'h0001);
    checks++; if (ps_out !== 2'b10 || ia_out !== 16'h0100) begin failures++; $display("FAIL call got ps=%b ia=%h exp ps=10 ia=0100", ps_out, ia_out); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0100);
    checks++; if (depth_out !== 4'd1 || ra_out !== model_q[$]) begin failures++; $display("FAIL after_call got depth=%0d ra=%h exp depth=1 ra=%h", depth_out, ra_out, model_q[$]); end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0105);
    exp_ra = model_q.pop_back();
    checks++; if (ps_out !== 2'b11 || ra_out !== exp_ra) begin failures++; $display("FAIL ret got ps=%b ra=%h exp ps=11 ra=%h", ps_out, ra_out, exp_ra); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0011);
    checks++; if (depth_out !== 4'd0 || ra_out !== 16'h0000) begin failures++; $display("FAIL after_ret got depth=%0d ra=%h exp depth=0 ra=0000", depth_out, ra_out); end
  endtask

  task automatic test_nested();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0300 + 16'(i)), 16'(16'h0200 + 16'(i * 3)));
      model_q.push_back(16'(16'h0200 + 16'(i * 3) + 16'h0001));
      checks++; if (ps_out !== 2'b10 || depth_out !== 4'(i)) begin failures++; $display("FAIL nest_call[%0d] got ps=%b depth=%0d exp ps=10 depth=%0d", i, ps_out, depth_out, i); end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0400);
    checks++; if (depth_out !== 4'd8) begin failures++; $display("FAIL nest_full got depth=%0d exp=8", depth_out); end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0500);
      exp_ra = model_q.pop_back();
      checks++; if (ps_out !== 2'b11 || ra_out !== exp_ra) begin failures++; $display("FAIL nest_ret[%0d] got ps=%b ra=%h exp ps=11 ra=%h", i, ps_out, ra_out, exp_ra); end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0500);
    checks++; if (depth_out !== 4'd0 || err_out !== 1'b0) begin failures++; $display("FAIL nest_empty got depth=%0d err=%b exp 0/0", depth_out, err_out); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0700, 16'(i));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0700, 16'h0008);
    checks++; if (ps_out !== 2'b00 || ia_out !== 16'h0000) begin failures++; $display("FAIL ovf_call got ps=%b ia=%h exp ps=00 ia=0000", ps_out, ia_out); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0700, 16'h0009);
      checks++; if (err_out !== 1'b1 || imem_req_out !== 1'b0 || ps_out !== 2'b00 || depth_out !== 4'd8) begin failures++; $display("FAIL ovf_error[%0d] got err=%b req=%b ps=%b depth=%0d exp 1/0/00/8", i, err_out, imem_req_out, ps_out, depth_out); end
    end
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checks++; if (ps_out !== 2'b00) begin failures++; $display("FAIL udf_ret got ps=%b exp=00", ps_out); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001);
    checks++; if (err_out !== 1'b1 || imem_req_out !== 1'b0) begin failures++; $display("FAIL udf_error got err=%b req=%b exp 1/0", err_out, imem_req_out); end
  endtask

  task automatic test_wrap_priority();
    do_reset();
    checks++; if (err_out !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", err_out); end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0800, 16'hFFFF);
    model_q.push_back(16'hFFFF + 16'h0001);
    checks++; if (ps_out !== 2'b10) begin failures++; $display("FAIL wrap_call got ps=%b exp=10", ps_out); end
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0900, 16'h0800);
    exp_ra = model_q.pop_back();
    checks++; if (ps_out !== 2'b11 || ra_out !== exp_ra || ia_out !== 16'h0000 || depth_out !== 4'd1) begin failures++; $display("FAIL ret_wins got ps=%b ra=%h ia=%h depth=%0d exp ps=11 ra=%h ia=0000 depth=1", ps_out, ra_out, ia_out, depth_out, exp_ra); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checks++; if (depth_out !== 4'd0) begin failures++; $display("FAIL ret_wins_depth got=%0d exp=0", depth_out); end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0A00, 16'(16'h0020 + 16'(i)));
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0B00, 16'h0A00);
    checks++; if (ps_out !== 2'b00 || imem_req_out !== 1'b1) begin failures++; $display("FAIL halt_req got ps=%b req=%b exp ps=00 req=1", ps_out, imem_req_out); end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0B00, 16'h0A00);
    checks++; if (ps_out !== 2'b00 || imem_req_out !== 1'b0 || depth_out !== 4'd3) begin failures++; $display("FAIL halted got ps=%b req=%b depth=%0d exp 00/0/3", ps_out, imem_req_out, depth_out); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0A00);
    checks++; if (imem_req_out !== 1'b0 || ps_out !== 2'b00) begin failures++; $display("FAIL resume_cycle got req=%b ps=%b exp 0/00", imem_req_out, ps_out); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0A00);
    checks++; if (imem_req_out !== 1'b1 || ps_out !== 2'b01 || depth_out !== 4'd3) begin failures++; $display("FAIL resumed got req=%b ps=%b depth=%0d exp 1/01/3", imem_req_out, ps_out, depth_out); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0A01);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0A01);
    checks++; if (imem_req_out !== 1'b0 || depth_out !== 4'd3 || ra_out !== 16'h0023) begin failures++; $display("FAIL rehalt got req=%b depth=%0d ra=%h exp 0/3/0023", imem_req_out, depth_out, ra_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (depth_out !== 4'd0 || ps_out !== 2'b00 || ra_out !== 16'h0000 || imem_req_out !== 1'b0) begin failures++; $display("FAIL async_reset got depth=%0d ps=%b ra=%h req=%b exp 0/00/0000/0", depth_out, ps_out, ra_out, imem_req_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_ready_stall();
    test_call_ret();
    test_nested();
    test_overflow();
    test_wrap_priority();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
